// File: rtl/hough_accum.sv
// -----------------------------------------------------------------------------
// hough_accum -- streaming slope/intercept Hough voter.
//
// Every edge pixel (PixelIn >= Threshold) votes once per slope bin m, all
// slopes in parallel, into the bin c = y - ((m*x) >> M_SHIFT). At each frame
// boundary the strongest (m, c) bin of the finished frame is published on
// Best* with a one-cycle ResultValid pulse, and the accumulator is cleared.
// The pixel stream is passed through one cycle late for downstream overlay.
//
// Ports
//   Clk, nReset          clock, synchronous active-low reset
//   PixelIn/FrameIn/LineIn  pixel stream (one pixel per cycle) and strobes
//   Threshold            edge threshold
//   PixelOut/FrameOut/LineOut  stream delayed by one cycle
//   BestM/BestC/BestVotes  peak bin and its vote count of the last frame
//   ResultValid          one-cycle pulse when Best* update
//
// Optional feature (macro HOUGH_MIN_VOTES_EN):
//   adds input MinVotes and output Found; Found updates with ResultValid and
//   is 1 iff the published BestVotes >= MinVotes.
// -----------------------------------------------------------------------------
module hough_accum #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 8,
  parameter int N_M     = 4,
  parameter int M_SHIFT = 2,
  parameter int N_C     = 16,
  parameter int CNT_W   = 8,
  localparam int MW = (N_M > 1) ? $clog2(N_M) : 1,
  localparam int CW = (N_C > 1) ? $clog2(N_C) : 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [PIX_W-1:0] PixelIn,
  input  logic             FrameIn,
  input  logic             LineIn,
  input  logic [PIX_W-1:0] Threshold,
  output logic [PIX_W-1:0] PixelOut,
  output logic             FrameOut,
  output logic             LineOut,
  output logic [MW-1:0]    BestM,
  output logic [CW-1:0]    BestC,
  output logic [CNT_W-1:0] BestVotes,
  output logic             ResultValid
`ifdef HOUGH_MIN_VOTES_EN
  ,
  input  logic [CNT_W-1:0] MinVotes,
  output logic             Found
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam int PW = COORD_W + MW;

  function automatic logic [COORD_W-1:0] coordInc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + COORD_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] voteInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Intercept for slope bin m, signed so that lines passing below y=0 at
  // this x fall out of range instead of wrapping into a valid bin.
  function automatic logic signed [COORD_W:0] interceptOf(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 m
  );
    logic [PW-1:0] prod;
    prod = (PW'(x) * PW'(m)) >> M_SHIFT;
    return $signed({1'b0, y}) - $signed(prod[COORD_W:0]);
  endfunction

  logic [0:0]         state;
  logic [COORD_W-1:0] xCnt, yCnt, curX, curY;
  logic               isEdge, accept;

  logic signed [COORD_W:0] cVal [N_M];
  logic [N_M-1:0]          hit;

  logic [N_M-1:0] vld_p1;
  logic [CW-1:0]  cIdx_p1 [N_M];
  logic           frame_p1, wasAccum_p1;

  logic [CNT_W-1:0] acc [N_M][N_C];
  logic [CNT_W-1:0] incVal [N_M];
  logic [CNT_W-1:0] peakVotes, nextVotes;
  logic [MW-1:0]    peakM, nextM;
  logic [CW-1:0]    peakC, nextC;

  logic             vld_p2;
  logic [MW-1:0]    pendM_p2;
  logic [CW-1:0]    pendC_p2;
  logic [CNT_W-1:0] pendVotes_p2;

  // Coordinates of the pixel currently on PixelIn.
  always_comb begin
    curX = coordInc(xCnt);
    curY = yCnt;
    if (FrameIn) begin
      curX = '0;
      curY = '0;
    end else if (LineIn) begin
      curX = '0;
      curY = coordInc(yCnt);
    end
  end

  // The pixel sampled with FrameIn already belongs to the new frame, so it
  // votes even when the FSM is still leaving IDLE.
  assign isEdge = (PixelIn >= Threshold);
  assign accept = FrameIn || (state == ACCUM);

  always_comb begin
    for (int m = 0; m < N_M; m++) begin
      cVal[m] = interceptOf(curX, curY, m);
      hit[m]  = isEdge && accept && !cVal[m][COORD_W] &&
                ({1'b0, cVal[m][COORD_W-1:0]} < (COORD_W+1)'(N_C));
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state    <= IDLE;
      xCnt     <= '0;
      yCnt     <= '0;
      PixelOut <= '0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
    end else begin
      if (FrameIn) state <= ACCUM;
      xCnt     <= curX;
      yCnt     <= curY;
      PixelOut <= PixelIn;
      FrameOut <= FrameIn;
      LineOut  <= LineIn;
    end
  end

  // ---- stage 1: per-slope intercept and vote enable ----
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      vld_p1      <= '0;
      frame_p1    <= 1'b0;
      wasAccum_p1 <= 1'b0;
    end else begin
      vld_p1      <= hit;
      frame_p1    <= FrameIn;
      wasAccum_p1 <= (state == ACCUM);
    end
  end

  always_ff @(posedge Clk) begin
    for (int m = 0; m < N_M; m++) cIdx_p1[m] <= cVal[m][CW-1:0];
  end

  // ---- stage 2: accumulate and track the running peak ----
  // On the boundary cycle (frame_p1) the old counts read as zero, so the new
  // frame's first pixel lands on a cleared accumulator instead of being lost.
  always_comb begin
    nextVotes = frame_p1 ? '0 : peakVotes;
    nextM     = frame_p1 ? '0 : peakM;
    nextC     = frame_p1 ? '0 : peakC;
    for (int m = 0; m < N_M; m++) begin
      incVal[m] = voteInc(frame_p1 ? '0 : acc[m][cIdx_p1[m]]);
      // Ascending scan with strict compare: lowest m wins a same-cycle tie
      // and an earlier peak survives a later equal one.
      if (vld_p1[m] && (incVal[m] > nextVotes)) begin
        nextVotes = incVal[m];
        nextM     = MW'(m);
        nextC     = cIdx_p1[m];
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int m = 0; m < N_M; m++) begin
      for (int c = 0; c < N_C; c++) begin
        if (!nReset)
          acc[m][c] <= '0;
        else if (vld_p1[m] && (cIdx_p1[m] == CW'(c)))
          acc[m][c] <= incVal[m];
        else if (frame_p1)
          acc[m][c] <= '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      peakVotes <= '0;
      peakM     <= '0;
      peakC     <= '0;
    end else begin
      peakVotes <= nextVotes;
      peakM     <= nextM;
      peakC     <= nextC;
    end
  end

  // Snapshot of the finished frame's peak, taken before the clear lands.
  always_ff @(posedge Clk) begin
    if (frame_p1) begin
      pendM_p2     <= peakM;
      pendC_p2     <= peakC;
      pendVotes_p2 <= peakVotes;
    end
  end

  // ---- stage 3: publish ----
  // A boundary seen while still IDLE closes a frame cut by reset: no result.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      vld_p2      <= 1'b0;
      ResultValid <= 1'b0;
      BestM       <= '0;
      BestC       <= '0;
      BestVotes   <= '0;
`ifdef HOUGH_MIN_VOTES_EN
      Found       <= 1'b0;
`endif
    end else begin
      vld_p2      <= frame_p1 && wasAccum_p1;
      ResultValid <= vld_p2;
      if (vld_p2) begin
        BestM     <= pendM_p2;
        BestC     <= pendC_p2;
        BestVotes <= pendVotes_p2;
`ifdef HOUGH_MIN_VOTES_EN
        Found     <= (pendVotes_p2 >= MinVotes);
`endif
      end
    end
  end

endmodule

// File: tb/tb_hough_accum.sv
module tb_hough_accum;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [7:0] PixelIn, Threshold;
  logic       FrameIn, LineIn;

  logic [7:0] pixOut8, pixOut4;
  logic       frameOut8, frameOut4, lineOut8, lineOut4;
  logic [1:0] bestM8, bestM4;
  logic [3:0] bestC8, bestC4;
  logic [7:0] bestVotes8;
  logic [3:0] bestVotes4;
  logic       rv8, rv4;
`ifdef HOUGH_MIN_VOTES_EN
  logic [7:0] minVotes8;
  logic [3:0] minVotes4;
  logic       found8, found4;
`endif

  always #5 Clk = ~Clk;

  hough_accum #(.CNT_W(8)) dut8 (
    .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
    .LineIn(LineIn), .Threshold(Threshold), .PixelOut(pixOut8),
    .FrameOut(frameOut8), .LineOut(lineOut8), .BestM(bestM8), .BestC(bestC8),
    .BestVotes(bestVotes8), .ResultValid(rv8)
`ifdef HOUGH_MIN_VOTES_EN
    , .MinVotes(minVotes8), .Found(found8)
`endif
  );

  hough_accum #(.CNT_W(4)) dut4 (
    .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
    .LineIn(LineIn), .Threshold(Threshold), .PixelOut(pixOut4),
    .FrameOut(frameOut4), .LineOut(lineOut4), .BestM(bestM4), .BestC(bestC4),
    .BestVotes(bestVotes4), .ResultValid(rv4)
`ifdef HOUGH_MIN_VOTES_EN
    , .MinVotes(minVotes4), .Found(found4)
`endif
  );

  int nChecks = 0;
  int nPass   = 0;
  int pulses8 = 0;

  logic       rvHist [3];
  logic       rv4At2;
  logic [1:0] capM8, capM4;
  logic [3:0] capC8, capC4;
  logic [7:0] capV8;
  logic [3:0] capV4;

  always @(negedge Clk) if (rv8) pulses8++;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] pixFor(input int kind, input int x, input int y);
    case (kind)
      1:       return (y == 5)      ? 8'd255 : 8'd0;
      2:       return (y == (x>>1)) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Drives nPix pixels of a 16x16 frame; records ResultValid over the first
  // three post-edge samples and the Best* values after the third.
  task automatic runFrame(input int kind, input int nPix);
    for (int i = 0; i < nPix; i++) begin
      PixelIn = pixFor(kind, i % 16, i / 16);
      FrameIn = (i == 0);
      LineIn  = ((i % 16) == 0);
      @(posedge Clk); #1;
      if (i < 3) rvHist[i] = rv8;
      if (i == 2) begin
        rv4At2 = rv4;
        capM8 = bestM8; capC8 = bestC8; capV8 = bestVotes8;
        capM4 = bestM4; capC4 = bestC4; capV4 = bestVotes4;
      end
      if (kind == 1 && i == 80) checkVal("lineOut", 32'(lineOut8), 32'd1);
      if (kind == 1 && i == 83) checkVal("pixOut", 32'(pixOut8), 32'd255);
      if (kind == 1 && i == 84) checkVal("frameOut0", 32'(frameOut8), 32'd0);
    end
    FrameIn = 1'b0;
    LineIn  = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic pulse, input int m,
                              input int c, input int v, input int v4);
    checkVal({tag, ".early"}, 32'({rvHist[0], rvHist[1]}), 32'd0);
    checkVal({tag, ".rv"}, 32'(rvHist[2]), 32'(pulse));
    checkVal({tag, ".rv4"}, 32'(rv4At2), 32'(pulse));
    checkVal({tag, ".m"}, 32'(capM8), 32'(m));
    checkVal({tag, ".c"}, 32'(capC8), 32'(c));
    checkVal({tag, ".votes"}, 32'(capV8), 32'(v));
    checkVal({tag, ".m4"}, 32'(capM4), 32'(m));
    checkVal({tag, ".c4"}, 32'(capC4), 32'(c));
    checkVal({tag, ".votes4"}, 32'(capV4), 32'(v4));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0; PixelIn = 8'd255; FrameIn = 1'b0; LineIn = 1'b0;
    Threshold = 8'd128;
`ifdef HOUGH_MIN_VOTES_EN
    minVotes8 = 8'd20; minVotes4 = 4'd15;
`endif
    repeat (3) @(posedge Clk);
    #1;
    checkVal("rst.pixOut", 32'(pixOut8), 32'd0);
    checkVal("rst.rv", 32'(rv8), 32'd0);
    checkVal("rst.votes", 32'(bestVotes8), 32'd0);
    checkVal("rst.mc", 32'({bestM8, bestC8}), 32'd0);
`ifdef HOUGH_MIN_VOTES_EN
    checkVal("rst.found", 32'(found8), 32'd0);
`endif

    // Pixels before the first FrameIn are ignored.
    nReset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;

    runFrame(1, 256);                       // horizontal line y=5
    expectResult("first", 1'b0, 0, 0, 0, 0);

    runFrame(2, 256);                       // line (x, x>>1)
    expectResult("horiz", 1'b1, 0, 5, 16, 15);
`ifdef HOUGH_MIN_VOTES_EN
    checkVal("found20", 32'(found8), 32'd0);
    minVotes8 = 8'd16;
`endif

    runFrame(0, 256);                       // empty
    expectResult("slope", 1'b1, 2, 0, 16, 15);
`ifdef HOUGH_MIN_VOTES_EN
    checkVal("found16", 32'(found8), 32'd1);
    checkVal("found4", 32'(found4), 32'd1);
`endif

    runFrame(1, 256);
    expectResult("empty", 1'b1, 0, 0, 0, 0);

    runFrame(2, 100);                       // cut short by reset below
    expectResult("horiz2", 1'b1, 0, 5, 16, 15);

    nReset = 1'b0; PixelIn = 8'd255;
    @(posedge Clk); #1;
    checkVal("midrst.pixOut", 32'(pixOut8), 32'd0);
    checkVal("midrst.votes", 32'(bestVotes8), 32'd0);
    checkVal("midrst.c", 32'(bestC8), 32'd0);
    @(posedge Clk); #1;
    nReset = 1'b1;

    runFrame(1, 256);
    expectResult("postrst", 1'b0, 0, 0, 0, 0);

    runFrame(0, 20);
    expectResult("recover", 1'b1, 0, 5, 16, 15);

    repeat (4) @(posedge Clk);
    #1;
    checkVal("pulseCount", 32'(pulses8), 32'd5);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
